entropy_harvester: RTL and testbench

ENTROPY_HARVESTER -- requirements
Module: entropy_harvester

---
 rtl/entropy_pkg.sv | 10 +
 rtl/sync_2ff.sv | 24 ++
 rtl/entropy_harvester.sv | 148 ++++++++++++++
 tb/tb_entropy_harvester.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/entropy_pkg.sv
// Shared types for the entropy harvester: controller state encoding.
package entropy_pkg;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_FULL  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one bit of the free-running oscillator bus.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/entropy_harvester.sv
// Ring-oscillator entropy harvester: periodic XOR sampling, von Neumann
// debiasing, word assembly with valid/ready handoff and a repetition health test.
module entropy_harvester
   import entropy_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int OUT_WIDTH  = 8,
   parameter int SAMPLE_DIV = 4,
   parameter int REP_LIMIT  = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WIDTH-1:0]     entropy_in,
   output logic [OUT_WIDTH-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 fault
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int RUN_W = $clog2(REP_LIMIT + 1);
   localparam int CNT_W = $clog2(OUT_WIDTH + 1);

   logic [WIDTH-1:0]     w_sync;
   logic [DIV_W-1:0]     r_div;
   logic                 w_tick;
   logic                 w_raw;
   logic                 r_phase;
   logic                 r_first;
   logic                 r_last;
   logic [RUN_W-1:0]     r_run;
   logic [RUN_W-1:0]     w_run_nxt;
   logic                 w_rep_fail;
   logic                 w_dvld;
   logic                 w_dbit;
   logic [OUT_WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_last_bit;
   logic                 w_hs;
   state_t               r_state;
   state_t               w_state_nxt;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_sync
         sync_2ff u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .i_d     (entropy_in[gi]),
            .o_q     (w_sync[gi])
         );
      end
   endgenerate

   // Divider wraps on the tick, so the first tick lands SAMPLE_DIV edges after release.
   assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_div <= '0;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + DIV_W'(1);
   end

   assign w_raw  = ^w_sync;
   assign w_dvld = w_tick && r_phase && (r_first != w_raw);
   assign w_dbit = r_first;

   // Run length saturates at the limit rather than wrapping.
   always_comb begin
      w_run_nxt = RUN_W'(1);
      if ((r_run != '0) && (w_raw == r_last))
         w_run_nxt = (r_run == RUN_W'(REP_LIMIT)) ? r_run : r_run + RUN_W'(1);
   end

   assign w_rep_fail = w_tick && (w_run_nxt == RUN_W'(REP_LIMIT));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
         r_run   <= '0;
      end else if (w_tick) begin
         r_phase <= ~r_phase;
         if (!r_phase) r_first <= w_raw;
         r_last  <= w_raw;
         r_run   <= w_run_nxt;
      end
   end

   assign w_last_bit = (r_cnt == CNT_W'(OUT_WIDTH - 1));
   assign w_hs       = (r_state == ST_FULL) && ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_FILL;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      valid       = 1'b0;
      fault       = 1'b0;
      data        = '0;
      case (r_state)
         ST_FILL: begin
            if (w_dvld && w_last_bit) w_state_nxt = ST_FULL;
         end
         ST_FULL: begin
            valid = 1'b1;
            data  = r_acc;
            if (w_hs) w_state_nxt = ST_FILL;
         end
         default: begin
            fault       = 1'b1;
            w_state_nxt = ST_FAULT;
         end
      endcase
      if (w_rep_fail) w_state_nxt = ST_FAULT;
   end

   // While FULL the word is frozen; a bit arriving with the handshake opens the next word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_dvld) begin
                  r_acc <= (r_acc << 1) | OUT_WIDTH'(w_dbit);
                  r_cnt <= w_last_bit ? '0 : r_cnt + CNT_W'(1);
               end
            end
            ST_FULL: begin
               if (w_hs) begin
                  r_cnt <= w_dvld ? CNT_W'(1) : '0;
                  if (w_dvld) r_acc <= (r_acc << 1) | OUT_WIDTH'(w_dbit);
               end
            end
            default: begin
               r_acc <= '0;
               r_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_entropy_harvester.sv
// Randomized bench for entropy_harvester against a tick-level behavioural model.
module tb_entropy_harvester;

   localparam int W  = 8;
   localparam int OW = 8;
   localparam int SD = 4;
   localparam int RL = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  entropy_in = '0;
   logic [OW-1:0] data;
   logic          valid;
   logic          ready = 1'b0;
   logic          fault;

   int n_chk  = 0;
   int n_pass = 0;

   // model state
   bit          cur_raw = 1'b0;
   bit          rnd_rdy = 1'b0;
   int          cyc = 0;
   int          run = 0;
   bit          prev = 1'b0;
   bit          have_a = 1'b0;
   bit          a = 1'b0;
   bit          m_valid = 1'b0;
   bit          m_fault = 1'b0;
   logic [OW-1:0] m_data = '0;
   bit          wq[$];
   bit          hs, dv, db;

   entropy_harvester #(
      .WIDTH      (W),
      .OUT_WIDTH  (OW),
      .SAMPLE_DIV (SD),
      .REP_LIMIT  (RL)
   ) dut (
      .clk        (clk),
      .reset_n    (rst_n),
      .entropy_in (entropy_in),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   // Behavioural reference: raw bits -> von Neumann pairs -> word queue -> handoff.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; run = 0; have_a = 0; m_valid = 0; m_fault = 0; m_data = '0;
         wq.delete();
      end else begin
         hs = m_valid && ready;
         dv = 0;
         db = 0;
         cyc++;
         if (!m_fault && (cyc % SD) == 0) begin
            if (run > 0 && cur_raw == prev) run++;
            else run = 1;
            prev = cur_raw;
            if (have_a) begin
               have_a = 0;
               if (a != cur_raw) begin dv = 1; db = a; end
            end else begin
               have_a = 1;
               a = cur_raw;
            end
            if (run >= RL) begin
               m_fault = 1; m_valid = 0; m_data = '0;
               wq.delete();
            end
         end
         if (!m_fault) begin
            if (m_valid) begin
               if (hs) begin
                  m_valid = 0;
                  if (dv) wq.push_back(db);
               end
            end else begin
               if (dv) wq.push_back(db);
               if (wq.size() == OW) begin
                  m_valid = 1;
                  m_data  = '0;
                  foreach (wq[i]) m_data = {m_data[OW-2:0], wq[i]};
                  wq.delete();
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("valid", valid, m_valid);
      check("fault", fault, m_fault);
      if (m_valid || m_fault || !rst_n) check("data", data, m_data);
   end

   // Starts and ends on the falling edge just after a sample tick.
   task automatic drive_raw(input bit r, input bit hs_at_tick, input bit zero);
      logic [W-1:0] v;
      v = W'($urandom);
      if ((^v) != r) v[0] = ~v[0];
      if (zero) v = '0;
      entropy_in = v;
      cur_raw    = r;
      if (rnd_rdy) ready = 1'($urandom);
      for (int i = 0; i < SD - 1; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (rnd_rdy) ready = 1'($urandom);
      end
      if (hs_at_tick) ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_pair(input bit d, input bit hs_at_tick);
      drive_raw(d, 1'b0, 1'b0);
      drive_raw(~d, hs_at_tick, 1'b0);
   endtask

   task automatic drive_word(input int nbits, inout logic [OW-1:0] w);
      bit d;
      for (int i = 0; i < nbits; i++) begin
         d = 1'($urandom);
         drive_pair(d, 1'b0);
         w = {w[OW-2:0], d};
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_fault", fault, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [OW-1:0] w;
      logic [OW-1:0] held;
      bit            d;

      repeat (3) @(negedge clk);
      check("init_valid", valid, 0);
      check("init_fault", fault, 0);
      rst_n = 1'b1;

      // fixed 10/01 pattern with ready high yields 0xAA
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_pair(1'b1, 1'b0);
         drive_pair(1'b0, 1'b0);
      end
      check("aa_valid", valid, 1);
      check("aa_data", data, 8'hAA);

      // only 00 / 11 pairs: nothing delivered, no fault
      do_reset();
      rnd_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         d = i[0];
         drive_raw(d, 1'b0, 1'b0);
         drive_raw(d, 1'b0, 1'b0);
      end
      rnd_rdy = 1'b0;
      check("eq_valid", valid, 0);
      check("eq_fault", fault, 0);

      // randomized traffic with random ready
      do_reset();
      rnd_rdy = 1'b1;
      for (int i = 0; i < 400; i++) drive_raw(1'($urandom), 1'b0, 1'b0);
      rnd_rdy = 1'b0;

      // back-pressure: word held while pairs keep arriving
      do_reset();
      ready = 1'b0;
      w = '0;
      drive_word(OW, w);
      check("bp_valid", valid, 1);
      check("bp_data", data, w);
      held = data;
      for (int i = 0; i < 26; i++) drive_raw(1'($urandom), 1'b0, 1'b0);
      check("bp_hold", data, held);
      check("bp_hold_valid", valid, 1);
      d = 1'($urandom);
      ready = 1'b1;
      drive_raw(d, 1'b0, 1'b0);
      ready = 1'b0;
      drive_raw(~d, 1'b0, 1'b0);
      w = '0;
      w = {w[OW-2:0], d};
      drive_word(OW - 1, w);
      check("post_hs_data", data, w);

      // handshake coinciding with a debiased bit
      do_reset();
      ready = 1'b0;
      w = '0;
      drive_word(OW, w);
      check("coin_full", valid, 1);
      d = 1'($urandom);
      drive_pair(d, 1'b1);
      ready = 1'b0;
      check("coin_hs", valid, 0);
      w = '0;
      w = {w[OW-2:0], d};
      drive_word(OW - 1, w);
      check("coin_data", data, w);
      check("coin_msb", data[OW-1], d);

      // reset mid-word, then reset while a word is pending
      do_reset();
      ready = 1'b1;
      w = '0;
      drive_word(5, w);
      do_reset();
      ready = 1'b0;
      w = '0;
      drive_word(OW, w);
      check("rst_word", data, w);
      do_reset();
      w = '0;
      drive_word(OW, w);
      check("fresh_word", data, w);

      // stuck input trips the repetition test on the 32nd tick
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < RL - 1; i++) drive_raw(1'b0, 1'b0, 1'b1);
      check("rep_pre", fault, 0);
      drive_raw(1'b0, 1'b0, 1'b1);
      check("rep_fault", fault, 1);
      check("rep_valid", valid, 0);
      check("rep_data", data, 0);
      rnd_rdy = 1'b1;
      for (int i = 0; i < 24; i++) drive_raw(1'($urandom), 1'b0, 1'b0);
      rnd_rdy = 1'b0;
      check("rep_sticky", fault, 1);
      check("rep_sticky_v", valid, 0);
      do_reset();
      check("rep_cleared", fault, 0);
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
